// File: rtl/aclock_set_ctrl.sv
// Alarm clock user controller: turns button pulses into BCD time/alarm edits
// and timed load/stop strobes for the clock datapath.
module aclock_set_ctrl #(
  parameter int LOAD_CYCLES = 10,
  parameter int TIMEOUT     = 200,
  parameter int SNOOZE_MIN  = 5
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_mode,
  input  logic       btn_inc,
  input  logic       btn_snooze,
  input  logic       alarm_active,
  input  logic [1:0] cur_h1,
  input  logic [3:0] cur_h0,
  input  logic [3:0] cur_m1,
  input  logic [3:0] cur_m0,
  output logic [1:0] H_in1,
  output logic [3:0] H_in0,
  output logic [3:0] M_in1,
  output logic [3:0] M_in0,
  output logic       LD_time,
  output logic       LD_alarm,
  output logic       STOP_al,
  output logic       AL_ON,
  output logic [1:0] edit_field,
  output logic       edit_target,
  output logic       busy
);

  typedef enum logic [3:0] {
    IDLE, T_HOUR, T_MIN, LOAD_T, A_HOUR, A_MIN, LOAD_A, SNOOZE, DISMISS
  } state_t;

  localparam int CMAX = (TIMEOUT > LOAD_CYCLES) ? TIMEOUT : LOAD_CYCLES;
  localparam int CW   = $clog2(CMAX + 1);
  localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT - 1);
  localparam logic [CW-1:0] LD_LAST = CW'(LOAD_CYCLES);

  state_t        state;
  logic [CW-1:0] cnt;
  logic [1:0]    e_h1, s_h1, inc_h1, sn_h1;
  logic [3:0]    e_h0, e_m1, e_m0, s_h0, s_m1, s_m0;
  logic [3:0]    inc_h0, inc_m1, inc_m0, sn_h0, sn_m1, sn_m0;
  logic [7:0]    min_sum;
  logic [5:0]    hr_sum;
  logic          any_btn;

  assign any_btn     = btn_snooze | btn_mode | btn_inc;
  assign busy        = (state != IDLE);
  assign edit_target = (state == A_HOUR) || (state == A_MIN) || (state == LOAD_A);
  assign edit_field  = ((state == T_HOUR) || (state == A_HOUR)) ? 2'd1 :
                       ((state == T_MIN)  || (state == A_MIN))  ? 2'd2 : 2'd0;

  // BCD increment of the field being edited; hour wraps 23->00, minute 59->00
  always_comb begin
    inc_h1 = e_h1;
    inc_h0 = e_h0 + 4'd1;
    if (e_h1 == 2'd2 && e_h0 == 4'd3) begin
      inc_h1 = 2'd0;
      inc_h0 = 4'd0;
    end else if (e_h0 == 4'd9) begin
      inc_h1 = e_h1 + 2'd1;
      inc_h0 = 4'd0;
    end
    inc_m1 = e_m1;
    inc_m0 = e_m0 + 4'd1;
    if (e_m0 == 4'd9) begin
      inc_m0 = 4'd0;
      inc_m1 = (e_m1 == 4'd5) ? 4'd0 : e_m1 + 4'd1;
    end
  end

  // Snooze target: current time plus SNOOZE_MIN minutes, done in binary
  always_comb begin
    min_sum = 8'(cur_m1) * 8'd10 + 8'(cur_m0) + 8'(SNOOZE_MIN);
    hr_sum  = 6'(cur_h1) * 6'd10 + 6'(cur_h0);
    if (min_sum >= 8'd60) begin
      min_sum = min_sum - 8'd60;
      hr_sum  = hr_sum + 6'd1;
    end
    if (hr_sum >= 6'd24) hr_sum = hr_sum - 6'd24;
    sn_m1 = 4'(min_sum / 8'd10);
    sn_m0 = 4'(min_sum % 8'd10);
    sn_h1 = 2'(hr_sum / 6'd10);
    sn_h0 = 4'(hr_sum % 6'd10);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      cnt      <= '0;
      {e_h1, e_h0, e_m1, e_m0} <= '0;
      {s_h1, s_h0, s_m1, s_m0} <= '0;
      {H_in1, H_in0, M_in1, M_in0} <= '0;
      LD_time  <= 1'b0;
      LD_alarm <= 1'b0;
      STOP_al  <= 1'b0;
      AL_ON    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          cnt <= '0;
          if (alarm_active) begin
            if (btn_snooze) begin
              state <= SNOOZE;
              {H_in1, H_in0, M_in1, M_in0} <= {sn_h1, sn_h0, sn_m1, sn_m0};
            end else if (btn_mode) begin
              state <= DISMISS;
              {H_in1, H_in0, M_in1, M_in0} <= {s_h1, s_h0, s_m1, s_m0};
            end
          end else if (!btn_snooze) begin
            if (btn_mode) begin
              state <= T_HOUR;
              {e_h1, e_h0, e_m1, e_m0} <= {cur_h1, cur_h0, cur_m1, cur_m0};
            end else if (btn_inc) begin
              AL_ON <= ~AL_ON;
            end
          end
        end
        T_HOUR, T_MIN, A_HOUR, A_MIN: begin
          if (any_btn) cnt <= '0;
          else if (cnt == TO_LAST) begin
            state <= IDLE;
            cnt   <= '0;
          end else cnt <= cnt + 1'b1;
          // snooze has no function here but still outranks mode/inc
          if (!btn_snooze) begin
            if (btn_mode) begin
              case (state)
                T_HOUR: state <= T_MIN;
                T_MIN: begin
                  state <= LOAD_T;
                  {H_in1, H_in0, M_in1, M_in0} <= {e_h1, e_h0, e_m1, e_m0};
                end
                A_HOUR: state <= A_MIN;
                A_MIN: begin
                  state <= LOAD_A;
                  {H_in1, H_in0, M_in1, M_in0} <= {e_h1, e_h0, e_m1, e_m0};
                  {s_h1, s_h0, s_m1, s_m0}     <= {e_h1, e_h0, e_m1, e_m0};
                end
                default: state <= IDLE;
              endcase
            end else if (btn_inc) begin
              if (state == T_HOUR || state == A_HOUR) {e_h1, e_h0} <= {inc_h1, inc_h0};
              else {e_m1, e_m0} <= {inc_m1, inc_m0};
            end
          end
        end
        LOAD_T, LOAD_A, SNOOZE, DISMISS: begin
          // strobes rise one cycle after entry and stay up for LOAD_CYCLES
          if (cnt == LD_LAST) begin
            cnt      <= '0;
            LD_time  <= 1'b0;
            LD_alarm <= 1'b0;
            STOP_al  <= 1'b0;
            if (state == LOAD_T) begin
              state <= A_HOUR;
              {e_h1, e_h0, e_m1, e_m0} <= {s_h1, s_h0, s_m1, s_m0};
            end else begin
              state <= IDLE;
              if (state == LOAD_A) AL_ON <= 1'b1;
            end
          end else begin
            cnt      <= cnt + 1'b1;
            LD_time  <= (state == LOAD_T);
            LD_alarm <= (state != LOAD_T);
            STOP_al  <= (state == SNOOZE) || (state == DISMISS);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_aclock_set_ctrl.sv
// Directed bench for aclock_set_ctrl: time/alarm edits, wraps, snooze,
// dismiss, timeout and reset during a load.
module tb_aclock_set_ctrl;
  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       btn_mode = 1'b0, btn_inc = 1'b0, btn_snooze = 1'b0;
  logic       alarm_active = 1'b0;
  logic [1:0] cur_h1 = '0;
  logic [3:0] cur_h0 = '0, cur_m1 = '0, cur_m0 = '0;
  logic [1:0] H_in1;
  logic [3:0] H_in0, M_in1, M_in0;
  logic       LD_time, LD_alarm, STOP_al, AL_ON, edit_target, busy;
  logic [1:0] edit_field;
  logic [13:0] hm;
  int total = 0;
  int bad = 0;

  assign hm = {H_in1, H_in0, M_in1, M_in0};

  aclock_set_ctrl #(.LOAD_CYCLES(10), .TIMEOUT(200), .SNOOZE_MIN(5)) dut (
    .clk(clk), .reset(reset), .btn_mode(btn_mode), .btn_inc(btn_inc),
    .btn_snooze(btn_snooze), .alarm_active(alarm_active),
    .cur_h1(cur_h1), .cur_h0(cur_h0), .cur_m1(cur_m1), .cur_m0(cur_m0),
    .H_in1(H_in1), .H_in0(H_in0), .M_in1(M_in1), .M_in0(M_in0),
    .LD_time(LD_time), .LD_alarm(LD_alarm), .STOP_al(STOP_al), .AL_ON(AL_ON),
    .edit_field(edit_field), .edit_target(edit_target), .busy(busy)
  );

  always #5 clk = ~clk;

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // mask = {snooze, mode, inc}; button is high across exactly one posedge
  task automatic pulse(input logic [2:0] mask);
    @(negedge clk);
    {btn_snooze, btn_mode, btn_inc} = mask;
    @(negedge clk);
    {btn_snooze, btn_mode, btn_inc} = 3'b000;
  endtask

  task automatic incs(input int n);
    for (int i = 0; i < n; i++) pulse(3'b001);
  endtask

  task automatic set_cur(input logic [13:0] v);
    {cur_h1, cur_h0, cur_m1, cur_m0} = v;
  endtask

  task automatic watch(input int n, output int lt, output int la, output int st);
    lt = 0; la = 0; st = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      lt += int'(LD_time);
      la += int'(LD_alarm);
      st += int'(STOP_al);
    end
  endtask

  task automatic test_reset;
    repeat (2) @(negedge clk);
    total++; if (hm !== 14'd0) begin bad++; $display("FAIL reset_hm got=%h want=0", hm); end
    total++; if ({LD_time, LD_alarm, STOP_al, AL_ON} !== 4'b0) begin
      bad++; $display("FAIL reset_strobes got=%b want=0000", {LD_time, LD_alarm, STOP_al, AL_ON}); end
    total++; if ({edit_field, edit_target, busy} !== 4'b0) begin
      bad++; $display("FAIL reset_status got=%b want=0000", {edit_field, edit_target, busy}); end
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_set_time;
    int lt, la, st;
    logic [13:0] exp;
    set_cur(14'd0);
    pulse(3'b010);
    total++; if ({edit_field, edit_target, busy} !== 4'b0101) begin
      bad++; $display("FAIL thour_status got=%b want=0101", {edit_field, edit_target, busy}); end
    incs(14);
    pulse(3'b010);
    total++; if (edit_field !== 2'd2) begin bad++; $display("FAIL tmin_field got=%0d want=2", edit_field); end
    incs(30);
    pulse(3'b010);
    exp = {2'd1, 4'd4, 4'd3, 4'd0};
    total++; if (hm !== exp) begin bad++; $display("FAIL load_t_hm got=%h want=%h", hm, exp); end
    total++; if (LD_time !== 1'b0) begin bad++; $display("FAIL load_t_entry_strobe got=%b want=0", LD_time); end
    watch(15, lt, la, st);
    total++; if (lt != 10) begin bad++; $display("FAIL load_t_len got=%0d want=10", lt); end
    total++; if (la + st != 0) begin bad++; $display("FAIL load_t_other got=%0d want=0", la + st); end
    total++; if ({edit_field, edit_target} !== 3'b011) begin
      bad++; $display("FAIL after_load_t got=%b want=011", {edit_field, edit_target}); end
  endtask

  task automatic test_set_alarm;
    int lt, la, st;
    logic [13:0] exp;
    incs(6);
    pulse(3'b010);
    incs(45);
    pulse(3'b010);
    exp = {2'd0, 4'd6, 4'd4, 4'd5};
    total++; if (hm !== exp) begin bad++; $display("FAIL load_a_hm got=%h want=%h", hm, exp); end
    total++; if ({edit_target, AL_ON} !== 2'b10) begin
      bad++; $display("FAIL load_a_entry got=%b want=10", {edit_target, AL_ON}); end
    watch(15, lt, la, st);
    total++; if (la != 10) begin bad++; $display("FAIL load_a_len got=%0d want=10", la); end
    total++; if (lt + st != 0) begin bad++; $display("FAIL load_a_other got=%0d want=0", lt + st); end
    total++; if ({AL_ON, busy} !== 2'b10) begin
      bad++; $display("FAIL after_load_a got=%b want=10", {AL_ON, busy}); end
  endtask

  task automatic test_al_toggle;
    pulse(3'b001);
    total++; if (AL_ON !== 1'b0) begin bad++; $display("FAIL al_toggle_off got=%b want=0", AL_ON); end
    pulse(3'b001);
    total++; if (AL_ON !== 1'b1) begin bad++; $display("FAIL al_toggle_on got=%b want=1", AL_ON); end
    alarm_active = 1'b1;
    pulse(3'b001);
    total++; if ({AL_ON, busy} !== 2'b10) begin
      bad++; $display("FAIL inc_while_ringing got=%b want=10", {AL_ON, busy}); end
    alarm_active = 1'b0;
  endtask

  task automatic test_wrap;
    logic [13:0] cur_v [3];
    logic [13:0] exp_v [3];
    int lt, la, st;
    cur_v[0] = {2'd2, 4'd3, 4'd5, 4'd9}; exp_v[0] = {2'd0, 4'd0, 4'd0, 4'd0};
    cur_v[1] = {2'd0, 4'd9, 4'd1, 4'd9}; exp_v[1] = {2'd1, 4'd0, 4'd2, 4'd0};
    cur_v[2] = {2'd1, 4'd9, 4'd0, 4'd9}; exp_v[2] = {2'd2, 4'd0, 4'd1, 4'd0};
    for (int k = 0; k < 3; k++) begin
      set_cur(cur_v[k]);
      pulse(3'b010);
      incs(1);
      pulse(3'b010);
      incs(1);
      pulse(3'b010);
      total++; if (hm !== exp_v[k]) begin bad++; $display("FAIL wrap%0d_hm got=%h want=%h", k, hm, exp_v[k]); end
      watch(15, lt, la, st);
      total++; if (lt != 10) begin bad++; $display("FAIL wrap%0d_len got=%0d want=10", k, lt); end
      repeat (205) @(negedge clk);
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL wrap%0d_abandon got=%b want=0", k, busy); end
    end
  endtask

  task automatic test_snooze;
    int lt, la, st;
    logic [13:0] exp;
    alarm_active = 1'b1;
    set_cur({2'd2, 4'd3, 4'd5, 4'd8});
    pulse(3'b100);
    exp = {2'd0, 4'd0, 4'd0, 4'd3};
    total++; if ({hm, busy} !== {exp, 1'b1}) begin
      bad++; $display("FAIL snooze_hm got=%h/%b want=%h/1", hm, busy, exp); end
    watch(15, lt, la, st);
    total++; if (st != 10 || la != 10 || lt != 0) begin
      bad++; $display("FAIL snooze_len got=st%0d la%0d lt%0d want=10/10/0", st, la, lt); end
    total++; if ({busy, AL_ON} !== 2'b01) begin
      bad++; $display("FAIL snooze_after got=%b want=01", {busy, AL_ON}); end
    set_cur({2'd1, 4'd0, 4'd5, 4'd7});
    pulse(3'b110);
    exp = {2'd1, 4'd1, 4'd0, 4'd2};
    total++; if (hm !== exp) begin bad++; $display("FAIL snooze_prio_hm got=%h want=%h", hm, exp); end
    watch(15, lt, la, st);
    total++; if (st != 10) begin bad++; $display("FAIL snooze_prio_len got=%0d want=10", st); end
    alarm_active = 1'b0;
  endtask

  task automatic test_dismiss;
    int lt, la, st;
    logic [13:0] exp;
    alarm_active = 1'b1;
    set_cur({2'd0, 4'd0, 4'd0, 4'd3});
    pulse(3'b010);
    exp = {2'd0, 4'd6, 4'd4, 4'd5};
    total++; if (hm !== exp) begin bad++; $display("FAIL dismiss_hm got=%h want=%h", hm, exp); end
    watch(15, lt, la, st);
    total++; if (st != 10 || la != 10 || lt != 0) begin
      bad++; $display("FAIL dismiss_len got=st%0d la%0d lt%0d want=10/10/0", st, la, lt); end
    total++; if ({busy, edit_field, AL_ON} !== 4'b0001) begin
      bad++; $display("FAIL dismiss_after got=%b want=0001", {busy, edit_field, AL_ON}); end
    alarm_active = 1'b0;
  endtask

  task automatic test_timeout;
    int lt, la, st;
    int lt_tot;
    set_cur({2'd1, 4'd2, 4'd3, 4'd4});
    pulse(3'b010);
    watch(150, lt, la, st);
    lt_tot = lt;
    pulse(3'b001);
    watch(199, lt, la, st);
    lt_tot += lt;
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL timeout_early got=%b want=1", busy); end
    @(negedge clk);
    lt_tot += int'(LD_time);
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL timeout_idle got=%b want=0", busy); end
    total++; if (lt_tot != 0) begin bad++; $display("FAIL timeout_no_load got=%0d want=0", lt_tot); end
  endtask

  task automatic test_reset_mid_load;
    int lt, la, st;
    set_cur(14'd0);
    pulse(3'b010);
    pulse(3'b010);
    pulse(3'b010);
    repeat (3) @(negedge clk);
    total++; if (LD_time !== 1'b1) begin bad++; $display("FAIL mid_load_high got=%b want=1", LD_time); end
    #2 reset = 1'b1;
    #1;
    total++; if ({LD_time, busy} !== 2'b00) begin
      bad++; $display("FAIL mid_load_reset got=%b want=00", {LD_time, busy}); end
    @(negedge clk);
    reset = 1'b0;
    watch(12, lt, la, st);
    total++; if (lt + la + st != 0 || busy !== 1'b0) begin
      bad++; $display("FAIL mid_load_no_retry got=%0d/%b want=0/0", lt + la + st, busy); end
  endtask

  initial begin
    test_reset;
    test_set_time;
    test_set_alarm;
    test_al_toggle;
    test_wrap;
    test_snooze;
    test_dismiss;
    test_timeout;
    test_reset_mid_load;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/aclock_set_ctrl.md
Name: aclock_set_ctrl

Overview:
- User-facing controller that sequences the alarm clock datapath.
- Turns debounced single-cycle button pulses (mode, inc, snooze) into BCD edits of time and alarm, plus timed LD_time/LD_alarm/STOP_al strobes.
- Owns AL_ON, snooze rescheduling and dismiss/restore of the user alarm.
- Sits between the button debouncer and the clock datapath. Runs on the same clk as the datapath.

Parameters:
- LOAD_CYCLES, 10: clk cycles each load/stop strobe is held. Must be ≥ one datapath 1 s tick period (10 clk), so the datapath samples it at least once.
- TIMEOUT, 200: idle clk cycles in an edit state before the edit is abandoned.
- SNOOZE_MIN, 5: minutes added on snooze. Legal range 1..59.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- btn_mode  in  1  one-cycle pulse: advance field / dismiss
- btn_inc  in  1  one-cycle pulse: increment field / toggle AL_ON
- btn_snooze  in  1  one-cycle pulse: snooze ringing alarm
- alarm_active  in  1  datapath Alarm output
- cur_h1  in  2  current hour tens (datapath H_out1)
- cur_h0  in  4  current hour units
- cur_m1  in  4  current minute tens
- cur_m0  in  4  current minute units
- H_in1  out  2  hour tens to datapath
- H_in0  out  4  hour units to datapath
- M_in1  out  4  minute tens to datapath
- M_in0  out  4  minute units to datapath
- LD_time  out  1  load time strobe
- LD_alarm  out  1  load alarm strobe
- STOP_al  out  1  stop alarm strobe
- AL_ON  out  1  alarm enable
- edit_field  out  2  0 none, 1 hour, 2 minute
- edit_target  out  1  0 time, 1 alarm
- busy  out  1  high in any non-IDLE state

Behaviour:
- Reset (async): state IDLE; edit regs, shadow alarm and H_in/M_in = 00:00. All strobes, AL_ON, edit_field, edit_target, busy = 0. Held H_in/M_in = 0 means the datapath starts at 00:00.
- States:
  - IDLE
  - T_HOUR, T_MIN (edit time)
  - LOAD_T
  - A_HOUR, A_MIN (edit alarm)
  - LOAD_A
  - SNOOZE
  - DISMISS
- Button priority in a single cycle: snooze > mode > inc. Lower-priority pulses in that cycle are dropped. All buttons are ignored in LOAD_T, LOAD_A, SNOOZE and DISMISS.
- IDLE with alarm_active = 1:
  - btn_snooze → SNOOZE.
  - btn_mode → DISMISS.
  - btn_inc is ignored.
- IDLE with alarm_active = 0:
  - btn_mode → T_HOUR; edit regs := cur_h1/h0/m1/m0.
  - btn_inc toggles AL_ON.
  - btn_snooze is ignored.
- Edit states:
  - btn_inc: hour steps 00..23 then wraps to 00 (BCD: 09→10, 19→20, 23→00). Minute steps 00..59 then wraps to 00; hour is not touched.
  - btn_mode: T_HOUR→T_MIN→LOAD_T→A_HOUR (edit regs := shadow alarm)→A_MIN→LOAD_A→IDLE.
- Timeout: an edit-state counter resets on any button pulse. At TIMEOUT cycles the FSM goes → IDLE with no load; the shadow alarm is unchanged.
- LOAD_T: LD_time = 1 for exactly LOAD_CYCLES cycles with H_in/M_in = edit regs. Next cycle → A_HOUR.
- LOAD_A:
  - LD_alarm = 1 for LOAD_CYCLES cycles.
  - Shadow alarm := edit regs on entry.
  - AL_ON := 1 on exit.
  - Then → IDLE.
- SNOOZE:
  - On entry, compute target = current time + SNOOZE_MIN minutes. Minute carry at 60; hour wrap 23→00.
  - Drive target on H_in/M_in. LD_alarm = 1 and STOP_al = 1 for LOAD_CYCLES cycles, then → IDLE.
  - The shadow alarm is not changed.
- DISMISS: drive shadow alarm on H_in/M_in. STOP_al = 1 and LD_alarm = 1 for LOAD_CYCLES cycles, restoring the user alarm after any snooze. Then → IDLE. AL_ON is unchanged.
- Outputs:
  - edit_field = 1 in *_HOUR, 2 in *_MIN, else 0.
  - edit_target = 1 in A_* / LOAD_A, else 0.
- H_in/M_in in IDLE hold the last driven value.
- All strobes are registered and glitch-free. A strobe rises the cycle after the state entry.
- Reset mid-load: strobes drop immediately (async); no partial load is retried.

Test Plan:
- Reset, then mode, inc×14, mode, inc×30, mode → LD_time high for 10 cycles with H_in=1,4 and M_in=3,0 (cur time 00:00). Datapath then reads 14:30:00.
- Hour wrap: in T_HOUR starting at 23, one inc → H_in1=0, H_in0=0. Minute 59 + inc → 00 with hour unchanged.
- Set alarm 06:45 through A_HOUR/A_MIN → LD_alarm held 10 cycles; AL_ON=1 after. At 06:45:00 alarm_active rises.
- Snooze at cur 23:58 with SNOOZE_MIN=5 → STOP_al and LD_alarm high 10 cycles, H_in/M_in=00:03. Shadow alarm still 06:45.
- Dismiss (btn_mode while alarm_active) → STOP_al and LD_alarm 10 cycles, H_in/M_in=06:45; FSM back in IDLE.
- Enter T_HOUR, no buttons for 200 cycles → IDLE, LD_time never asserted. Assert reset during LOAD_T → LD_time=0 that same cycle and busy=0.
